aidc_lite_block_out_buf: RTL
============================

// Module: aidc_lite_block_out_buf
// PURPOSE
//  Downstream of the AIDC-Lite code concatenator. Captures the up-to-8 addressed 64-bit code words
//  of one compressed block plus the matching raw 512-bit block, then streams a single 64-bit
//  beat sequence over a valid/ready interface. Compressed words are sent when the block fits;
//  the raw words are sent when compression failed.
// PARAMETERS
//  NUM_WORDS  8   max words per block; wr_addr_i and all word counters are sized from it
//  WORD_W     64  beat / code-word width; the raw block is NUM_WORDS*WORD_W bits
// PORTS
//  clk         in   1        clock; single clock domain
//  rst_n       in   1        asynchronous, active-low reset
//  wr_valid_i  in   1        code-word write strobe from the concatenator
//  wr_addr_i   in   3        code-word index, 0..NUM_WORDS-1
//  wr_data_i   in   WORD_W   code word, MSB-first bitstream
//  done_i      in   1        level; block complete; the 0->1 edge is the event
//  fail_i      in   1        level; valid on done_i rise; 1 = compressed size > 512 bits
//  raw_valid_i in   1        strobe that captures the raw block
//  raw_data_i  in   512      raw block; word k = raw_data_i[511-64k -: 64]
//  busy_o      out  1        high while draining; upstream must not start a new block
//  valid_o     out  1        output beat valid
//  ready_i     in   1        output beat accepted when valid_o & ready_i
//  data_o      out  WORD_W   output beat
//  comp_o      out  1        1 = beat is compressed code; 0 = beat is raw; constant within a block
//  last_o      out  1        final beat of the block
//  err_o       out  1        sticky protocol error; cleared only by reset
// BEHAVIOUR
//  Reset (async assert, sync deassert is the integrator's job): FSM=IDLE.
//  - Outputs: busy_o, valid_o, last_o, comp_o and err_o = 0; data_o = 0.
//  - Internal: wr_cnt = 0, raw_ok = 0, done_q = 1.
//  - done_q resets to 1 because the concatenator holds done_i=1 out of reset. No spurious edge.
//  done_rise = done_i & ~done_q; done_q <= done_i every cycle.
//  IDLE:
//  - wr_valid_i writes buf[wr_addr_i] and sets wr_cnt = max(wr_cnt, wr_addr_i+1).
//  - raw_valid_i loads the raw register and sets raw_ok = 1.
//  - On done_rise, go to DRAIN and latch mode: comp = ~fail_i & (wr_cnt_eff != 0).
//    - wr_cnt_eff includes a write in the same cycle. A write coincident with done_rise is
//      captured and counted.
//    - Beat count N = comp ? wr_cnt_eff : NUM_WORDS.
//    - comp=0 with raw_ok=0 (raw not captured): set err_o and still stream the raw register.
//  DRAIN:
//  - busy_o = 1.
//  - valid_o is asserted the cycle after done_rise. Latency from done_rise to first valid_o is 1 clk.
//  - Beat i, i = 0..N-1: data_o = comp ? buf[i] : raw word i; last_o = (i == N-1).
//  - data_o, comp_o and last_o hold stable while valid_o & ~ready_i. No bubbles while ready_i stays high.
//  - On acceptance of the last beat:
//    - Next cycle: valid_o = 0 and busy_o = 0; return to IDLE.
//    - wr_cnt = 0, raw_ok = 0.
//    - Word buffer contents are not cleared; they are don't-care.
//  - wr_valid_i, raw_valid_i or done_rise during DRAIN: ignored and set err_o. The buffer is not corrupted.
//  - fail_i/done_i changes after the latch do not affect the current block.
//  - wr_addr_i >= NUM_WORDS (parameter variants only): write dropped, err_o set.
//  Async reset mid-DRAIN: immediately returns to reset state. A partial block is discarded with no last_o.
// TESTING
//  1. Reset with done_i=1, then hold 10 clk. Required: no valid_o, busy_o=0, err_o=0.
//  2. Writes at addr 0..3 with data 64'hA0..A3. done_i rises with fail_i=0 on the addr-3 write cycle.
//     Required: 4 beats A0..A3, comp_o=1, last_o on the 4th beat, first valid 1 clk after the edge.
//  3. raw_valid_i with raw=512'h00..3F bytes. 8 writes, then done with fail_i=1.
//     Required: 8 raw beats, word 0 = 64'h0001020304050607, comp_o=0, last_o on beat 8.
//  4. Case 2 with ready_i toggling 1010...
//     Required: each beat held until accepted, order preserved, exactly 4 handshakes.
//  5. wr_valid_i during DRAIN. Required: err_o=1 sticky; streamed data unchanged.
//  6. Assert rst_n=0 after beat 2 of 8, then run a fresh 2-word block.
//     Required: outputs 0 immediately; new block streams 2 beats only, and wr_cnt does not carry over.

Source files
------------

// File: rtl/aidc_lite_block_out_buf.sv
// aidc_lite_block_out_buf: captures one block's code words and raw words, then streams
// either the compressed words or the raw words as 64-bit valid/ready beats.
module aidc_lite_block_out_buf #(
  parameter int NUM_WORDS = 8,
  parameter int WORD_W    = 64,
  localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int CW = $clog2(NUM_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_valid_i,
  input  logic [AW-1:0]               wr_addr_i,
  input  logic [WORD_W-1:0]           wr_data_i,
  input  logic                        done_i,
  input  logic                        fail_i,
  input  logic                        raw_valid_i,
  input  logic [NUM_WORDS*WORD_W-1:0] raw_data_i,
  output logic                        busy_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [WORD_W-1:0]           data_o,
  output logic                        comp_o,
  output logic                        last_o,
  output logic                        err_o
);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_n;
  logic [WORD_W-1:0] mem     [NUM_WORDS];
  logic [WORD_W-1:0] raw_mem [NUM_WORDS];
  logic [CW-1:0] wr_cnt, wr_cnt_eff, n, addr_p1;
  logic [AW-1:0] idx;
  logic raw_ok, done_q, comp, err;
  logic done_rise, addr_ok, wr_ok, fire, last_fire, mode_comp;
  always_comb begin
    done_rise  = done_i & ~done_q;
    addr_ok    = 32'(wr_addr_i) < NUM_WORDS;
    wr_ok      = (state == IDLE) & wr_valid_i & addr_ok;
    addr_p1    = CW'(wr_addr_i) + CW'(1);
    wr_cnt_eff = (wr_ok && addr_p1 > wr_cnt) ? addr_p1 : wr_cnt;
    mode_comp  = ~fail_i & (wr_cnt_eff != '0);
    busy_o     = state == DRAIN;
    valid_o    = busy_o;
    comp_o     = busy_o & comp;
    last_o     = busy_o & (CW'(idx) + CW'(1) == n);
    data_o     = !busy_o ? '0 : comp ? mem[idx] : raw_mem[idx];
    fire       = valid_o & ready_i;
    last_fire  = fire & last_o;
    err_o      = err;
    state_n    = (state == IDLE) ? (done_rise ? DRAIN : IDLE) : (last_fire ? IDLE : DRAIN);
  end
  // Storage is written only while idle, so a drain always reads a frozen block.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr_i] <= wr_data_i;
    if (state == IDLE && raw_valid_i)
      for (int k = 0; k < NUM_WORDS; k++)
        raw_mem[k] <= raw_data_i[(NUM_WORDS-1-k)*WORD_W +: WORD_W];
  end
  // done_q resets high: upstream holds done_i=1 out of reset, which must not look like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_cnt <= '0;
      raw_ok <= 1'b0;
      done_q <= 1'b1;
      comp   <= 1'b0;
      n      <= '0;
      idx    <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= done_i;
      if (state == IDLE) begin
        wr_cnt <= wr_cnt_eff;
        if (raw_valid_i) raw_ok <= 1'b1;
        if (wr_valid_i && !addr_ok) err <= 1'b1;
        if (done_rise) begin
          comp <= mode_comp;
          n    <= mode_comp ? wr_cnt_eff : CW'(NUM_WORDS);
          idx  <= '0;
          if (!mode_comp && !(raw_ok || raw_valid_i)) err <= 1'b1;
        end
      end else begin
        if (fire) idx <= idx + AW'(1);
        if (last_fire) begin
          wr_cnt <= '0;
          raw_ok <= 1'b0;
        end
        if (wr_valid_i || raw_valid_i || done_rise) err <= 1'b1;
      end
    end
  end
endmodule
